i2c_byte_master: RTL and testbench

//  Bit-level I2C master engine sitting directly below the Wishbone I2C register block.
//  It consumes the block's latched address, data and start strobes.
//  It runs one single-byte transaction per start: START, addr+R/W, ACK, data, ACK/NACK, STOP.
//  It drives the open-drain SCL/SDA pads and returns busy/done/ack_err and the read byte,

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_tick_gen.sv | 52 +++++
 rtl/i2c_byte_master.sv | 237 +++++++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the single-byte I2C master:
//   state_t  - transaction FSM states, IDLE..STOP
//   I2C_RD / I2C_WR - value of the R/W bit appended to the 7-bit address
//   phase_t, Q0..Q3 - quarter-bit phases of one SCL bit cell
// ---------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR,
      ADDR_ACK,
      WDATA,
      WACK,
      RDATA,
      RACK,
      STOP
   } state_t;

   localparam logic I2C_RD = 1'b1;
   localparam logic I2C_WR = 1'b0;

   typedef logic [1:0] phase_t;

   localparam phase_t Q0 = 2'd0;
   localparam phase_t Q1 = 2'd1;
   localparam phase_t Q2 = 2'd2;
   localparam phase_t Q3 = 2'd3;

endpackage

// File: rtl/i2c_tick_gen.sv
// ---------------------------------------------------------------------------
// i2c_tick_gen
// Quarter-bit prescaler. Counts 0..max(divisor,1)-1 while enabled and pulses
// tick for one clk at the terminal count. Held cleared while disabled.
//   clk     in  system clock
//   reset   in  asynchronous, active-high reset
//   en      in  1 while a transaction is in progress
//   divisor in  clk cycles per quarter SCL period (0 behaves as 1)
//   tick    out one-clk pulse per quarter period
// ---------------------------------------------------------------------------
module i2c_tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [DIV_W-1:0] divisor,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] lim_q, lim_d;
   logic [DIV_W-1:0] lim_new;

   // The limit is captured only at reload, so a divisor change made
   // mid-count never truncates or stretches the quarter in progress.
   // NOTE: every always_comb output gets a default first, otherwise a path
   // that skips the assignment would infer a latch.
   always_comb begin
      lim_new = (divisor == '0) ? DIV_W'(1) : divisor;
      tick    = en && (cnt_q == lim_q - DIV_W'(1));
      cnt_d   = cnt_q + DIV_W'(1);
      lim_d   = lim_q;
      if (!en || tick) begin
         cnt_d = '0;
         lim_d = lim_new;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the values from before the edge, independent of block order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         lim_q <= DIV_W'(1);
      end else begin
         cnt_q <= cnt_d;
         lim_q <= lim_d;
      end
   end

endmodule

// File: rtl/i2c_byte_master.sv
// ---------------------------------------------------------------------------
// i2c_byte_master
// Bit-level I2C master: one single-byte transaction per accepted start
// (START, addr+R/W, ACK, data, ACK/NACK, STOP). Master-only, no stretching.
//   clk       in    system clock
//   reset     in    asynchronous, active-high reset
//   divisor   in    clk cycles per quarter SCL period (0 behaves as 1)
//   dev_addr  in    7-bit slave address, sampled on accepted start
//   wr_data   in    byte to write, sampled on accepted start
//   start_wr  in    rising edge starts a write transaction
//   start_rd  in    rising edge starts a read transaction (write wins a tie)
//   i2c_sclk  out   SCL, driven 0/1
//   i2c_sdat  inout SDA, driven 0 or released
//   rd_data   out   byte from last completed read
//   busy      out   transaction in progress
//   done      out   sticky, set at STOP completion, cleared on start
//   ack_err   out   sticky, slave NACKed addr or write data, cleared on start
// ---------------------------------------------------------------------------
module i2c_byte_master
   import i2c_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] divisor,
   input  logic [6:0]       dev_addr,
   input  logic [7:0]       wr_data,
   input  logic             start_wr,
   input  logic             start_rd,
   output logic             i2c_sclk,
   inout  wire              i2c_sdat,
   output logic [7:0]       rd_data,
   output logic             busy,
   output logic             done,
   output logic             ack_err
);

   state_t     state_q, state_d;
   phase_t     phase_q, phase_d, phase_nx;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] addr_byte_q, addr_byte_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       nack_q, nack_d;
   logic       scl_q, scl_d;
   logic       sda_oe_q, sda_oe_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       ack_err_q, ack_err_d;
   // "input was low last cycle"; cleared by reset so a start level held
   // high through reset is not mistaken for a fresh edge.
   logic       wr_low_q, wr_low_d;
   logic       rd_low_q, rd_low_d;

   logic       tick;
   logic       wr_rise, rd_rise;
   logic       sda_in;

   i2c_tick_gen #(.DIV_W(DIV_W)) u_tick (
      .clk     (clk),
      .reset   (reset),
      .en      (state_q != IDLE),
      .divisor (divisor),
      .tick    (tick)
   );

   assign sda_in   = i2c_sdat;
   assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;
   assign i2c_sclk = scl_q;
   assign rd_data  = rd_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign ack_err  = ack_err_q;

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      bit_cnt_d   = bit_cnt_q;
      addr_byte_d = addr_byte_q;
      wdata_d     = wdata_q;
      rx_d        = rx_q;
      rd_data_d   = rd_data_q;
      nack_d      = nack_q;
      scl_d       = scl_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      done_d      = done_q;
      ack_err_d   = ack_err_q;
      wr_low_d    = ~start_wr;
      rd_low_d    = ~start_rd;
      wr_rise     = start_wr & wr_low_q;
      rd_rise     = start_rd & rd_low_q;
      phase_nx    = phase_t'(phase_q + 2'd1);

      if (state_q == IDLE) begin
         if (wr_rise || rd_rise) begin
            state_d     = START;
            phase_d     = Q0;
            bit_cnt_d   = 3'd0;
            addr_byte_d = {dev_addr, wr_rise ? I2C_WR : I2C_RD};
            wdata_d     = wr_data;
            done_d      = 1'b0;
            ack_err_d   = 1'b0;
            busy_d      = 1'b1;
         end
      end else if (tick) begin
         phase_d = phase_nx;

         // End of a 4-tick cell: pick the state that owns the next cell.
         if (phase_q == Q3) begin
            case (state_q)
               START: state_d = ADDR;
               ADDR, WDATA, RDATA: begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_d == 3'd0) begin
                     case (state_q)
                        ADDR:    state_d = ADDR_ACK;
                        WDATA:   state_d = WACK;
                        default: state_d = RACK;
                     endcase
                  end
               end
               ADDR_ACK: begin
                  if (nack_q) begin
                     ack_err_d = 1'b1;
                     state_d   = STOP;
                  end else if (addr_byte_q[0] == I2C_RD) begin
                     state_d = RDATA;
                  end else begin
                     state_d = WDATA;
                  end
               end
               WACK: begin
                  if (nack_q) ack_err_d = 1'b1;
                  state_d = STOP;
               end
               RACK: begin
                  rd_data_d = rx_q;
                  state_d   = STOP;
               end
               STOP: begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
               default: state_d = IDLE;
            endcase
         end

         // Pad action for the quarter being entered, in the state owning it.
         case (state_d)
            IDLE: begin
               scl_d    = 1'b1;
               sda_oe_d = 1'b0;
            end
            START: begin
               if (phase_nx == Q1) sda_oe_d = 1'b1;
               else if (phase_nx == Q3) scl_d = 1'b0;
            end
            STOP: begin
               case (phase_nx)
                  Q0: begin
                     scl_d    = 1'b0;
                     sda_oe_d = 1'b1;
                  end
                  Q1:      scl_d    = 1'b1;
                  Q2:      sda_oe_d = 1'b0;
                  default: ;
               endcase
            end
            default: begin
               case (phase_nx)
                  Q0: begin
                     scl_d = 1'b0;
                     // ~bit_cnt_d is 7-bit_cnt_d: MSB first.
                     case (state_d)
                        ADDR:    sda_oe_d = ~addr_byte_q[~bit_cnt_d];
                        WDATA:   sda_oe_d = ~wdata_q[~bit_cnt_d];
                        default: sda_oe_d = 1'b0;
                     endcase
                  end
                  Q1: scl_d = 1'b1;
                  Q2: begin
                     case (state_q)
                        ADDR_ACK, WACK: nack_d = sda_in;
                        RDATA:          rx_d   = {rx_q[6:0], sda_in};
                        default:        ;
                     endcase
                  end
                  default: ;
               endcase
            end
         endcase
      end
   end

   // NOTE: the datapath registers are reset as well; they are few and this
   // keeps rd_data and the bus pads defined from the first cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         phase_q     <= Q0;
         bit_cnt_q   <= 3'd0;
         addr_byte_q <= 8'h00;
         wdata_q     <= 8'h00;
         rx_q        <= 8'h00;
         rd_data_q   <= 8'h00;
         nack_q      <= 1'b0;
         scl_q       <= 1'b1;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ack_err_q   <= 1'b0;
         wr_low_q    <= 1'b0;
         rd_low_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         bit_cnt_q   <= bit_cnt_d;
         addr_byte_q <= addr_byte_d;
         wdata_q     <= wdata_d;
         rx_q        <= rx_d;
         rd_data_q   <= rd_data_d;
         nack_q      <= nack_d;
         scl_q       <= scl_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ack_err_q   <= ack_err_d;
         wr_low_q    <= wr_low_d;
         rd_low_q    <= rd_low_d;
      end
   end

endmodule

// File: tb/tb_i2c_byte_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_byte_master
// Directed bench for i2c_byte_master with a behavioural slave/bus observer.
// Each start pushes its expected outcome; a monitor pops and compares when
// done rises.
// ---------------------------------------------------------------------------
module tb_i2c_byte_master;

   localparam int         DIV_W      = 16;
   localparam logic [6:0] SLAVE_ADDR = 7'h27;

   logic             clk = 1'b0;
   logic             reset;
   logic [DIV_W-1:0] divisor;
   logic [6:0]       dev_addr;
   logic [7:0]       wr_data;
   logic             start_wr;
   logic             start_rd;
   logic             scl;
   wire              sda;
   logic [7:0]       rd_data;
   logic             busy;
   logic             done;
   logic             ack_err;

   logic             slave_oe = 1'b0;

   pullup (sda);
   assign sda = slave_oe ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_byte_master #(.DIV_W(DIV_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .divisor  (divisor),
      .dev_addr (dev_addr),
      .wr_data  (wr_data),
      .start_wr (start_wr),
      .start_rd (start_rd),
      .i2c_sclk (scl),
      .i2c_sdat (sda),
      .rd_data  (rd_data),
      .busy     (busy),
      .done     (done),
      .ack_err  (ack_err)
   );

   typedef struct {
      string name;
      int    addr;
      int    aack;
      int    data;
      int    dack;
      int    rises;
      int    aerr;
      int    rd;
      int    lat;
      int    accept_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // ---------------- slave model + bus observer ----------------
   bit         slave_en    = 1'b1;
   bit         data_ack_en = 1'b1;
   logic [7:0] slave_rd_byte = 8'h3C;
   logic       scl_p = 1'b1;
   logic       sda_p = 1'b1;
   int         rises = 0;
   logic [7:0] obs_addr = 8'h00;
   logic [7:0] obs_data = 8'h00;
   logic       aack = 1'b1;
   logic       dack = 1'b1;
   logic       stop_seen = 1'b0;
   logic       match = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         slave_oe  = 1'b0;
         rises     = 0;
         stop_seen = 1'b0;
         match     = 1'b0;
      end else if (scl && scl_p && sda_p && !sda) begin
         rises     = 0;
         stop_seen = 1'b0;
         match     = 1'b0;
         obs_addr  = 8'h00;
         obs_data  = 8'h00;
         aack      = 1'b1;
         dack      = 1'b1;
      end else if (scl && scl_p && !sda_p && sda) begin
         stop_seen = 1'b1;
         slave_oe  = 1'b0;
      end else if (scl && !scl_p) begin
         if (rises < 8)        obs_addr = {obs_addr[6:0], sda};
         else if (rises == 8)  aack     = sda;
         else if (rises < 17)  obs_data = {obs_data[6:0], sda};
         else if (rises == 17) dack     = sda;
         rises++;
      end else if (!scl && scl_p) begin
         // SCL just fell: set up SDA for cell number 'rises'.
         if (rises == 8) begin
            match    = slave_en && (obs_addr[7:1] == SLAVE_ADDR);
            slave_oe = match;
         end else if (rises >= 9 && rises <= 16) begin
            slave_oe = match && obs_addr[0] && !slave_rd_byte[16 - rises];
         end else if (rises == 17) begin
            slave_oe = match && !obs_addr[0] && data_ack_en;
         end else begin
            slave_oe = 1'b0;
         end
      end
      scl_p = scl;
      sda_p = sda;
   end

   // ---------------- scoreboard monitor ----------------
   logic done_p = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (!reset && done && !done_p) begin
         check("expectation_pending", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, "_latency"}, cyc - e.accept_cyc, e.lat);
            check({e.name, "_busy"},    int'(busy), 0);
            check({e.name, "_ack_err"}, int'(ack_err), e.aerr);
            check({e.name, "_rd_data"}, int'(rd_data), e.rd);
            check({e.name, "_addr"},    int'(obs_addr), e.addr);
            check({e.name, "_addr_ack"}, int'(aack), e.aack);
            check({e.name, "_scl_rises"}, rises, e.rises);
            check({e.name, "_stop"},    int'(stop_seen), 1);
            if (e.rises == 19) begin
               check({e.name, "_data"},     int'(obs_data), e.data);
               check({e.name, "_data_ack"}, int'(dack), e.dack);
            end
         end
      end
      done_p = done;
   end

   // ---------------- stimulus ----------------
   function automatic exp_t mk(input string name, input int addr, input int aack_v,
                               input int data, input int dack_v, input int rises_v,
                               input int aerr, input int rd, input int lat);
      exp_t e;
      e.name = name; e.addr = addr; e.aack = aack_v; e.data = data;
      e.dack = dack_v; e.rises = rises_v; e.aerr = aerr; e.rd = rd;
      e.lat = lat; e.accept_cyc = 0;
      return e;
   endfunction

   task automatic issue(input exp_t e, input bit wr, input bit rd,
                        input bit push, input logic [7:0] d);
      @(negedge clk);
      dev_addr = SLAVE_ADDR;
      wr_data  = d;
      start_wr = wr;
      start_rd = rd;
      e.accept_cyc = cyc + 1;
      if (push) exp_q.push_back(e);
      @(negedge clk);
      start_wr = 1'b0;
      start_rd = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("txn_timeout", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      divisor  = 16'd4;
      dev_addr = 7'h00;
      wr_data  = 8'h00;
      start_wr = 1'b0;
      start_rd = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_scl",     int'(scl), 1);
      check("reset_sda",     int'(sda), 1);
      check("reset_busy",    int'(busy), 0);
      check("reset_done",    int'(done), 0);
      check("reset_ack_err", int'(ack_err), 0);
      check("reset_rd_data", int'(rd_data), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Write 0xA5 to 0x27: address byte 0x4E, 80 ticks x 4 clk.
      issue(mk("wr", 8'h4E, 0, 8'hA5, 0, 19, 0, 8'h00, 320), 1'b1, 1'b0, 1'b1, 8'hA5);
      wait_idle(2000);

      // Read from 0x27: address byte 0x4F, slave returns 0x3C, master NACKs.
      issue(mk("rd", 8'h4F, 0, 8'h3C, 1, 19, 0, 8'h3C, 320), 1'b0, 1'b1, 1'b1, 8'h00);
      wait_idle(2000);

      // No slave: addr NACK, data phase skipped, 44 ticks.
      slave_en = 1'b0;
      issue(mk("addr_nack", 8'h4E, 1, 0, 0, 10, 1, 8'h3C, 176), 1'b1, 1'b0, 1'b1, 8'hA5);
      wait_idle(2000);
      slave_en = 1'b1;

      // Slave NACKs the write data byte.
      data_ack_en = 1'b0;
      issue(mk("data_nack", 8'h4E, 0, 8'h81, 1, 19, 1, 8'h3C, 320), 1'b1, 1'b0, 1'b1, 8'h81);
      wait_idle(2000);
      data_ack_en = 1'b1;

      // start_rd pulse in the middle of a write is dropped, not queued.
      issue(mk("wr_mid_rd", 8'h4E, 0, 8'h33, 0, 19, 0, 8'h3C, 320), 1'b1, 1'b0, 1'b1, 8'h33);
      repeat (100) @(negedge clk);
      start_rd = 1'b1;
      @(negedge clk);
      start_rd = 1'b0;
      wait_idle(2000);
      repeat (20) @(negedge clk);
      check("no_queued_start", int'(busy), 0);

      // Both starts in the same cycle: write wins.
      issue(mk("wr_rd_same", 8'h4E, 0, 8'hC3, 0, 19, 0, 8'h3C, 320), 1'b1, 1'b1, 1'b1, 8'hC3);
      wait_idle(2000);
      repeat (20) @(negedge clk);
      check("same_cycle_single_txn", int'(busy), 0);

      // Reset in ADDR cell 3 at q0 (SCL low, SDA driven low for bit 0).
      issue(mk("aborted", 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 8'hA5);
      repeat (65) @(negedge clk);
      check("pre_reset_scl",  int'(scl), 0);
      check("pre_reset_sda",  int'(sda), 0);
      check("pre_reset_busy", int'(busy), 1);
      reset = 1'b1;
      #1;
      check("mid_reset_scl",  int'(scl), 1);
      check("mid_reset_sda",  int'(sda), 1);
      check("mid_reset_busy", int'(busy), 0);
      check("mid_reset_done", int'(done), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      issue(mk("after_reset", 8'h4E, 0, 8'h5A, 0, 19, 0, 8'h00, 320), 1'b1, 1'b0, 1'b1, 8'h5A);
      wait_idle(2000);

      // divisor=0 behaves as 1: 80 ticks = 80 clk.
      divisor = 16'd0;
      issue(mk("div0", 8'h4E, 0, 8'hFF, 0, 19, 0, 8'h00, 80), 1'b1, 1'b0, 1'b1, 8'hFF);
      wait_idle(1000);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
